// File: rtl/tri_pixel_sink.sv
// Captures rasterizer pixel strobes into an 8x8 bitmap and reports count, duplicate and order errors.
// Latency: capture takes effect at the strobe edge; row reads return one cycle after rd_en.
// Backpressure: none. Reads issued during CAPTURE are dropped, and po_in outside CAPTURE is ignored.
module tri_pixel_sink #(
  parameter int CHECK_ORDER = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       busy_in,
  input  logic       po_in,
  input  logic [2:0] xo_in,
  input  logic [2:0] yo_in,
  input  logic       rd_en,
  input  logic [2:0] rd_row,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic [6:0] pix_count,
  output logic       dup_err,
  output logic       order_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_REPORT  = 2'd2
  } state_t;

  localparam logic LP_CHECK = (CHECK_ORDER != 0);

  state_t      r_state;
  state_t      w_next_state;
  logic [63:0] r_bitmap;
  logic [5:0]  r_prev_key;
  logic        r_have_prev;
  logic [6:0]  r_pix_count;
  logic        r_dup_err;
  logic        r_order_err;
  logic        r_done;
  logic [7:0]  r_rd_data;
  logic        r_rd_valid;

  logic [5:0]  w_key;
  logic        w_bit_set;
  logic        w_start;
  logic        w_capture_pt;
  logic        w_capture_end;
  logic        w_order_bad;
  logic        w_rd_accept;

  // Key is {y,x}, so a plain unsigned compare gives raster order.
  assign w_key         = {yo_in, xo_in};
  assign w_bit_set     = r_bitmap[w_key];
  assign w_start       = (r_state != S_CAPTURE) && busy_in;
  assign w_capture_pt  = (r_state == S_CAPTURE) && busy_in && po_in;
  assign w_capture_end = (r_state == S_CAPTURE) && !busy_in;
  assign w_order_bad   = LP_CHECK && r_have_prev && (w_key <= r_prev_key);
  assign w_rd_accept   = rd_en && (r_state != S_CAPTURE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: busy_in rising starts a triangle, busy_in falling ends it.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (busy_in)  w_next_state = S_CAPTURE;
      S_CAPTURE: if (!busy_in) w_next_state = S_REPORT;
      S_REPORT:  if (busy_in)  w_next_state = S_CAPTURE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Capture datapath: clear on triangle start, accumulate points, flag done on end.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitmap    <= '0;
      r_prev_key  <= '0;
      r_have_prev <= 1'b0;
      r_pix_count <= '0;
      r_dup_err   <= 1'b0;
      r_order_err <= 1'b0;
      r_done      <= 1'b0;
    end else if (w_start) begin
      r_bitmap    <= '0;
      r_prev_key  <= '0;
      r_have_prev <= 1'b0;
      r_pix_count <= '0;
      r_dup_err   <= 1'b0;
      r_order_err <= 1'b0;
      r_done      <= 1'b0;
    end else if (w_capture_pt) begin
      r_bitmap[w_key] <= 1'b1;
      if (w_bit_set) begin
        r_dup_err <= 1'b1;
      end else if (r_pix_count < 7'd64) begin
        r_pix_count <= r_pix_count + 7'd1;
      end
      if (w_order_bad) begin
        r_order_err <= 1'b1;
      end
      // Duplicates still advance the previous-point key.
      r_prev_key  <= w_key;
      r_have_prev <= 1'b1;
    end else if (w_capture_end) begin
      r_done <= 1'b1;
    end
  end

  // Row read port: one-cycle latency, data held when no read is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_rd_data <= r_bitmap[{rd_row, 3'b000} +: 8];
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign done      = r_done;
  assign pix_count = r_pix_count;
  assign dup_err   = r_dup_err;
  assign order_err = r_order_err;

endmodule

// File: doc/tri_pixel_sink.md
TRI_PIXEL_SINK -- requirements
Module: tri_pixel_sink

Interface
REQ-001 Parameter CHECK_ORDER, default 1, meaning 1 enables the raster-order check and 0 forces order_err to 0.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 busy_in  input  1  rasterizer busy; high for the whole duration of one triangle.
REQ-005 po_in  input  1  pixel-valid strobe; each sampled cycle with po_in=1 carries one point.
REQ-006 xo_in  input  3  pixel x coordinate, 0..7.
REQ-007 yo_in  input  3  pixel y coordinate, 0..7.
REQ-008 rd_en  input  1  bitmap row read request.
REQ-009 rd_row  input  3  row (y) index to read.
REQ-010 rd_data  output  8  bitmap row; bit k = pixel (x=k, y=rd_row).
REQ-011 rd_valid  output  1  rd_data is valid this cycle.
REQ-012 done  output  1  results of the last triangle are stable.
REQ-013 pix_count  output  7  number of distinct pixels captured, 0..64.
REQ-014 dup_err  output  1  a pixel was reported more than once in the triangle.
REQ-015 order_err  output  1  a pixel arrived out of raster order (y ascending, then x ascending).

Function
REQ-016 The block SHALL have the states IDLE, CAPTURE and REPORT, held in a registered state variable.
REQ-017 IDLE or REPORT with busy_in=1 SHALL move to CAPTURE next cycle, clearing the 64-bit bitmap, pix_count, dup_err, order_err and done in that same edge.
REQ-018 CAPTURE with busy_in=1 and po_in=1 SHALL set bitmap bit (yo_in*8+xo_in) at the clock edge.
REQ-019 A CAPTURE point whose bit is already set SHALL set dup_err sticky and SHALL leave pix_count unchanged.
REQ-020 A CAPTURE point whose bit is clear SHALL increment pix_count by 1; pix_count SHALL never exceed 64.
REQ-021 With CHECK_ORDER=1, the second and later points of a triangle SHALL set order_err sticky unless the key {y,x} is strictly greater than the previous point's key; the first point SHALL never flag.
REQ-022 A duplicate point SHALL update the previous-point register like any other point.
REQ-023 CAPTURE with busy_in=0 SHALL move to REPORT next cycle, set done=1, and ignore po_in in that cycle.
REQ-024 po_in, xo_in and yo_in SHALL be ignored in IDLE and REPORT.
REQ-025 REPORT SHALL hold done, pix_count, dup_err, order_err and the bitmap unchanged until the next busy_in rise.
REQ-026 rd_en=1 in IDLE or REPORT SHALL give rd_data = bitmap row rd_row with rd_valid=1 on the next cycle, i.e. 1-cycle latency.
REQ-027 rd_en=1 in CAPTURE SHALL be ignored: rd_valid=0 next cycle and rd_data holds its last value.
REQ-028 rd_valid SHALL be 0 in any cycle not following an accepted rd_en; back-to-back reads SHALL be accepted every cycle.
REQ-029 Arithmetic: the bitmap index is 6 bits unsigned; the order compare is on a 6-bit unsigned {y,x}; no signed math.

Reset
REQ-030 While reset=1 at an edge, the block SHALL set state=IDLE, the bitmap to all zero, pix_count=0, dup_err=0, order_err=0, done=0, rd_valid=0 and rd_data=0.
REQ-031 Reset SHALL take priority over all inputs, including mid-CAPTURE; no partial result SHALL survive reset.
REQ-032 After reset, a busy_in that is already high SHALL start a capture on the first non-reset edge.

Verification
REQ-033 Single triangle with points (0,0),(1,0),(2,0),(0,1),(1,1),(0,2) and then busy_in low -> done=1, pix_count=6, dup_err=0, order_err=0; row reads give row0=0x07, row1=0x03, row2=0x01, rows 3..7=0x00.
REQ-034 Point (3,3) presented twice in one triangle -> dup_err=1 and pix_count=1.
REQ-035 Points (5,2) then (1,1) -> order_err=1; the same stimulus with CHECK_ORDER=0 -> order_err=0.
REQ-036 Full 8x8 raster of 64 points -> pix_count=64, every row reads 0xFF, and rd_valid follows rd_en by exactly 1 cycle on back-to-back reads.
REQ-037 rd_en during CAPTURE -> rd_valid=0; po_in=1 in IDLE -> bitmap unchanged; a second triangle -> previous results cleared on the busy_in rise.
REQ-038 reset asserted after 3 captured points -> all outputs 0, state IDLE; the next triangle then captures normally.
